// File: rtl/input_tile_feeder_if.sv
// Write-side handshake bundle for the input tile feeder.
// The master drives beats, the slave (the feeder) returns ready.
interface input_tile_feeder_if #(
    parameter int W = 512
);
    logic         wr_valid;
    logic         wr_ready;
    logic [W-1:0] wr_data;

    modport master (
        output wr_valid,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/input_tile_feeder.sv
// Ping-pong tile buffer feeding the systolic input skew array.
// Buffers whole tiles, replays them gap-free, then flushes with zeros.
module input_tile_feeder #(
    parameter int HIGHT      = 32,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input_tile_feeder_if.slave          wr,
    output logic [DATA_WIDTH*HIGHT-1:0] out,
    output logic                        out_enable,
    output logic                        tile_done,
    output logic                        drain_done
);
    localparam int W  = DATA_WIDTH * HIGHT;
    localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FW = $clog2(HIGHT) + 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_FLUSH  = 2'd2;

    logic [W-1:0]  mem_q [2][DEPTH];
    logic [W-1:0]  mem_d [2][DEPTH];
    logic [1:0]    full_q, full_d;
    logic          wb_q, wb_d;
    logic          rb_q, rb_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic [CW-1:0] rcnt_q, rcnt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic [1:0]    state_q, state_d;
    logic [W-1:0]  out_q, out_d;
    logic          en_q, en_d;
    logic          tile_done_q, tile_done_d;
    logic          drain_done_q, drain_done_d;
    logic          accept;

    assign wr.wr_ready = ~full_q[wb_q];
    assign accept      = wr.wr_valid & ~full_q[wb_q];

    assign out        = out_q;
    assign out_enable = en_q;
    assign tile_done  = tile_done_q;
    assign drain_done = drain_done_q;

    // Capture an accepted beat into the current write bank.
    always_comb begin
        mem_d = mem_q;
        if (accept) begin
            mem_d[wb_q][wcnt_q] = wr.wr_data;
        end
    end

    // Write pointer bookkeeping plus the read/replay state machine.
    always_comb begin
        full_d       = full_q;
        wb_d         = wb_q;
        wcnt_d       = wcnt_q;
        rb_d         = rb_q;
        rcnt_d       = rcnt_q;
        fcnt_d       = fcnt_q;
        state_d      = state_q;
        out_d        = out_q;
        en_d         = en_q;
        tile_done_d  = 1'b0;
        drain_done_d = 1'b0;

        if (accept) begin
            if (wcnt_q == CW'(DEPTH - 1)) begin
                full_d[wb_q] = 1'b1;
                wb_d         = ~wb_q;
                wcnt_d       = '0;
            end else begin
                wcnt_d = wcnt_q + CW'(1);
            end
        end

        unique case (state_q)
            S_IDLE: begin
                out_d = '0;
                en_d  = 1'b0;
                if (full_q[rb_q]) begin
                    out_d   = mem_q[rb_q][0];
                    en_d    = 1'b1;
                    rcnt_d  = CW'(1);
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (tile_done_q) begin
                    if (full_q[rb_q]) begin
                        out_d  = mem_q[rb_q][0];
                        rcnt_d = CW'(1);
                    end else if (HIGHT == 1) begin
                        out_d   = '0;
                        en_d    = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        out_d        = '0;
                        fcnt_d       = FW'(1);
                        drain_done_d = (HIGHT == 2);
                        state_d      = S_FLUSH;
                    end
                end else begin
                    out_d = mem_q[rb_q][rcnt_q];
                    if (rcnt_q == CW'(DEPTH - 1)) begin
                        tile_done_d  = 1'b1;
                        full_d[rb_q] = 1'b0;
                        drain_done_d = (HIGHT == 1) && !full_d[~rb_q];
                        rb_d         = ~rb_q;
                        rcnt_d       = '0;
                    end else begin
                        rcnt_d = rcnt_q + CW'(1);
                    end
                end
            end
            S_FLUSH: begin
                out_d = '0;
                if (fcnt_q == FW'(HIGHT - 1)) begin
                    en_d    = 1'b0;
                    fcnt_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    fcnt_d       = fcnt_q + FW'(1);
                    drain_done_d = (fcnt_q + FW'(1) == FW'(HIGHT - 1));
                end
            end
            default: begin
                out_d   = '0;
                en_d    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Tile storage carries no reset; the full flags gate every use.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q       <= '0;
            wb_q         <= 1'b0;
            wcnt_q       <= '0;
            rb_q         <= 1'b0;
            rcnt_q       <= '0;
            fcnt_q       <= '0;
            state_q      <= S_IDLE;
            out_q        <= '0;
            en_q         <= 1'b0;
            tile_done_q  <= 1'b0;
            drain_done_q <= 1'b0;
        end else begin
            full_q       <= full_d;
            wb_q         <= wb_d;
            wcnt_q       <= wcnt_d;
            rb_q         <= rb_d;
            rcnt_q       <= rcnt_d;
            fcnt_q       <= fcnt_d;
            state_q      <= state_d;
            out_q        <= out_d;
            en_q         <= en_d;
            tile_done_q  <= tile_done_d;
            drain_done_q <= drain_done_d;
        end
    end
endmodule

// File: tb/tb_input_tile_feeder.sv
// Self-checking bench for input_tile_feeder.
// Reference model schedules whole tiles and flush runs as output queues.
module tb_input_tile_feeder;
    localparam int H  = 4;
    localparam int DW = 16;
    localparam int D  = 4;
    localparam int W  = H * DW;

    typedef struct packed {
        logic [W-1:0] v;
        logic         en;
        logic         td;
        logic         dd;
    } ent_t;

    logic         clk;
    logic         rst;
    logic [W-1:0] out;
    logic         out_enable;
    logic         tile_done;
    logic         drain_done;

    input_tile_feeder_if #(.W(W)) wr_if ();

    input_tile_feeder #(
        .HIGHT(H),
        .DATA_WIDTH(DW),
        .DEPTH(D)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wr(wr_if),
        .out(out),
        .out_enable(out_enable),
        .tile_done(tile_done),
        .drain_done(drain_done)
    );

    always #5 clk = ~clk;

    ent_t         sched[$];
    logic [W-1:0] pending[$];
    logic [W-1:0] partial[$];
    ent_t         exp_e;
    int           n_full;
    bit           last_end;
    int           n_asserts;
    int           n_fail;
    int           en_cnt;
    int           td_cnt;
    int           dd_cnt;
    int           beat;

    task automatic chk(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
        n_asserts++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        sched.delete();
        pending.delete();
        partial.delete();
        exp_e    = '0;
        n_full   = 0;
        last_end = 0;
    endtask

    task automatic push_tile();
        ent_t e;
        for (int i = 0; i < D; i++) begin
            e.v  = pending.pop_front();
            e.en = 1'b1;
            e.td = (i == D - 1);
            e.dd = 1'b0;
            sched.push_back(e);
        end
    endtask

    task automatic push_flush();
        ent_t e;
        for (int i = 0; i < H - 1; i++) begin
            e.v  = '0;
            e.en = 1'b1;
            e.td = 1'b0;
            e.dd = (i == H - 2);
            sched.push_back(e);
        end
        e = '0;
        sched.push_back(e);
    endtask

    task automatic model_edge(input logic v, input logic [W-1:0] d);
        bit rdy;
        rdy = (n_full < 2);
        if (sched.size() == 0) begin
            if (pending.size() > 0) push_tile();
            else if (last_end) push_flush();
        end
        if (sched.size() > 0) exp_e = sched.pop_front();
        else exp_e = '0;
        if (exp_e.td) n_full--;
        last_end = exp_e.td;
        if (v && rdy) begin
            partial.push_back(d);
            if (partial.size() == D) begin
                foreach (partial[i]) pending.push_back(partial[i]);
                partial.delete();
                n_full++;
            end
        end
    endtask

    task automatic check_all();
        chk("out", out, exp_e.v);
        chk("out_enable", W'(out_enable), W'(exp_e.en));
        chk("tile_done", W'(tile_done), W'(exp_e.td));
        chk("drain_done", W'(drain_done), W'(exp_e.dd));
        chk("wr_ready", W'(wr_if.wr_ready), W'(n_full < 2));
        if (out_enable) en_cnt++;
        if (tile_done) td_cnt++;
        if (drain_done) dd_cnt++;
    endtask

    task automatic cycle(input logic v, input logic [W-1:0] d);
        wr_if.wr_valid = v;
        wr_if.wr_data  = d;
        @(posedge clk);
        model_edge(v, d);
        @(negedge clk);
        check_all();
    endtask

    function automatic logic [W-1:0] mkvec(input int k);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < H; i++) r[DW*i +: DW] = DW'(16 * k + i);
        return r;
    endfunction

    task automatic clr();
        en_cnt = 0;
        td_cnt = 0;
        dd_cnt = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, '0);
    endtask

    task automatic write_beats(input int n, input bit gaps);
        int  acc;
        int  cyc;
        bit  rdy;
        logic v;
        acc = 0;
        cyc = 0;
        while (acc < n && cyc < 200) begin
            rdy = (n_full < 2);
            v   = gaps ? ((cyc % 2) == 0) : 1'b1;
            cycle(v, mkvec(beat));
            if (v && rdy) begin
                acc++;
                beat++;
            end
            cyc++;
        end
        chk("write_budget", W'(acc), W'(n));
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        wr_if.wr_valid = 1'b0;
        wr_if.wr_data  = '0;
        n_asserts = 0;
        n_fail    = 0;
        beat      = 0;
        model_reset();
        clr();
        repeat (2) @(negedge clk);
        check_all();
        rst = 1'b0;

        clr();
        write_beats(4, 1'b0);
        idle(12);
        chk("single_en", W'(en_cnt), W'(7));
        chk("single_td", W'(td_cnt), W'(1));
        chk("single_dd", W'(dd_cnt), W'(1));

        clr();
        write_beats(8, 1'b0);
        idle(16);
        chk("two_en", W'(en_cnt), W'(11));
        chk("two_td", W'(td_cnt), W'(2));
        chk("two_dd", W'(dd_cnt), W'(1));

        clr();
        write_beats(12, 1'b0);
        idle(20);
        chk("three_en", W'(en_cnt), W'(15));
        chk("three_td", W'(td_cnt), W'(3));

        clr();
        write_beats(4, 1'b1);
        idle(12);
        chk("gaps_en", W'(en_cnt), W'(7));

        write_beats(4, 1'b0);
        idle(2);
        #2 rst = 1'b1;
        #1;
        chk("rst_out", out, '0);
        chk("rst_en", W'(out_enable), W'(0));
        chk("rst_ready", W'(wr_if.wr_ready), W'(1));
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_all();
        clr();
        write_beats(4, 1'b0);
        idle(12);
        chk("post_rst_en", W'(en_cnt), W'(7));

        clr();
        write_beats(4, 1'b0);
        idle(3);
        write_beats(4, 1'b0);
        idle(14);
        chk("flush_ovl_en", W'(en_cnt), W'(14));
        chk("flush_ovl_dd", W'(dd_cnt), W'(2));

        for (int i = 0; i < 300; i++) begin
            cycle(($urandom_range(0, 3) != 0), {$urandom, $urandom});
        end
        idle(40);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asserts, n_fail);
        $finish;
    end
endmodule

// File: doc/input_tile_feeder.md
# input_tile_feeder

Ping-pong tile buffer directly upstream of the input triangle skew array of the 32x32 systolic array. Accepts one unskewed column vector (HIGHT lanes of DATA_WIDTH bits) per handshake beat, buffers whole tiles of DEPTH vectors, and replays each full tile as a gap-free stream. The stream drives the skew array's `in` and `enable`. After the last buffered tile, HIGHT-1 zero vectors are appended so skewed data fully exits the array.

## Interface
- `HIGHT`, 32, lanes per vector (matches skew array height)
- `DATA_WIDTH`, 16, bits per lane
- `DEPTH`, 16, vectors per tile (K dimension); must be ≥ 2
- `clk` input 1 — single clock, rising edge.
- `rst` input 1 — asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `wr_valid` input 1 — upstream beat valid.
- `wr_ready` output 1 — feeder can accept a beat.
- `wr_data` input DATA_WIDTH*HIGHT — column vector. Lane r is bits [DATA_WIDTH*(r+1)-1 -: DATA_WIDTH].
- `out` output DATA_WIDTH*HIGHT — vector to skew array `in`; same lane order.
- `out_enable` output 1 — drives skew array `enable`.
- `tile_done` output 1 — one-cycle pulse coincident with the last data vector of a tile on `out`.
- `drain_done` output 1 — one-cycle pulse coincident with the last flush vector.

## Operation
- Storage: two banks (0, 1) of DEPTH x (DATA_WIDTH*HIGHT) registers.
  - Per-bank `full` flag.
  - Write bank pointer `wb` and write index `wcnt`.
  - Read bank pointer `rb` and read index `rcnt`.
- Write side:
  - `wr_ready` = !full[wb] (combinational).
  - Beat accepted on an edge with `wr_valid && wr_ready`: writes mem[wb][wcnt], increments wcnt.
  - On the beat where wcnt == DEPTH-1: set full[wb], toggle wb, wcnt <= 0.
  - `wr_valid` gaps are allowed; wcnt holds across gaps.
- Read FSM states: IDLE, STREAM, FLUSH.
  - IDLE: `out`=0, `out_enable`=0. If full[rb], next edge loads out<=mem[rb][0], out_enable<=1, rcnt<=1 and enters STREAM.
  - STREAM: each edge loads out<=mem[rb][rcnt] and increments rcnt.
    - When the vector with index DEPTH-1 is loaded: assert tile_done for that cycle, clear full[rb] on the same edge, toggle rb.
    - On the following edge, if full[new rb] is set, continue STREAM with index 0 (no bubble).
    - Otherwise load out<=0, keep out_enable=1, fcnt<=1 and enter FLUSH.
  - FLUSH: emits zero vectors with out_enable=1 for exactly HIGHT-1 cycles total. drain_done is asserted on the last of them; the next edge goes to IDLE with out_enable=0. Flush always completes, even if a bank fills meanwhile; that tile starts from IDLE afterwards.
  - HIGHT==1: FLUSH is skipped. drain_done pulses together with tile_done, and the FSM goes to IDLE.
- Banks never alias: a bank is written only while !full and read only while full. Write-completion on one bank and read-release on the other in the same edge are both honoured.
- Data is passed through unmodified; no arithmetic.

## Timing
- Reset (async assert) values:
  - outputs: out=0, out_enable=0, tile_done=0, drain_done=0
  - state: full=00, wb=rb=0, wcnt=rcnt=fcnt=0, FSM=IDLE
  - wr_ready=1 while rst is low after reset.
- Reset deasserted synchronously by the environment. Mid-operation reset discards all buffered tiles and any in-progress flush.
- Latency: last beat of a tile accepted at edge E → first vector on `out` after edge E+1 (from IDLE).
- Back-to-back tiles: DEPTH consecutive enabled cycles per tile, no gaps.
- Throughput: 1 vector/cycle sustained with two banks, provided the writer keeps pace.
- Backpressure: wr_ready falls the cycle after the second bank fills. It rises the cycle after the read side releases a bank, i.e. after the edge that loads index DEPTH-1.
- All outputs except wr_ready are registered.

## Test plan
- Single tile (HIGHT=4, DEPTH=4; lane r of beat k = 16*k+r) → out_enable high 4+3=7 cycles. Vectors 0..3 match input; then 3 zero vectors. tile_done on cycle 4, drain_done on cycle 7; first vector one cycle after the last write.
- Two tiles written back-to-back → 8 contiguous data cycles with no zero between tiles. tile_done at cycles 4 and 8, then 3 flush cycles, one drain_done.
- Three tiles with wr_valid held high → wr_ready low after the second tile fills, until the first tile's index 3 is loaded. All 12 vectors appear in order, none dropped or duplicated.
- Writer gaps (wr_valid toggling 1,0,1,0…) → tile still forms 4 correct vectors. Output starts only after the 4th accepted beat.
- rst pulsed during STREAM (after 2 vectors out) → out=0, out_enable=0, wr_ready=1 immediately. A fresh tile afterwards streams correctly from index 0.
- Tile completes during FLUSH of the previous tile → flush runs its full 3 cycles. Then 1 IDLE cycle (out_enable=0), then the new tile streams.
